reverser_arbiter: RTL and testbench
===================================

// Module: reverser_arbiter
// PURPOSE
//  Two-requester round-robin arbiter sharing one bit-reverser datapath (width 2**N).
//  Each requester presents a word plus a reverse flag over a valid/ready handshake.
//  The winner's word passes through the shared reverser (reversed if flag set, else unchanged).
//  The result is registered into a single-entry output stage tagged with the source ID.
//  Sits between two producers and one downstream consumer.
// PARAMETERS
//  N     3   data width is 2**N bits (8 by default)
// PORTS
//  clk        in   1     system clock, all state on rising edge
//  reset_n    in   1     asynchronous, active-low reset
//  in0_valid  in   1     requester 0 has a word
//  in0_data   in   2**N  requester 0 word
//  in0_rev    in   1     1 = reverse bit order, 0 = pass unchanged
//  in0_ready  out  1     requester 0 word accepted this cycle
//  in1_valid  in   1     requester 1 has a word
//  in1_data   in   2**N  requester 1 word
//  in1_rev    in   1     requester 1 reverse flag
//  in1_ready  out  1     requester 1 word accepted this cycle
//  out_valid  out  1     output register holds a result
//  out_data   out  2**N  result word
//  out_src    out  1     requester ID (0/1) that produced out_data
//  out_ready  in   1     consumer takes the result this cycle
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0, last_grant=1.
//    With last_grant=1, requester 0 wins the first contention.
//  - Handshake: a transfer occurs on any rising edge where valid && ready.
//    Producers hold valid/data/rev stable until ready. Consumer rule is identical.
//  - Output stage states: EMPTY (out_valid=0) / FULL (out_valid=1).
//    Slot is free when EMPTY, or when FULL and out_ready=1 (same-cycle replace).
//    EMPTY -> FULL on accept. FULL -> EMPTY on out_ready with no accept.
//    FULL -> FULL on out_ready with accept (new word loaded).
//  - Grant (combinational, only while slot free):
//    Only one valid: that requester is granted.
//    Both valid: the requester != last_grant is granted.
//    Neither valid: no grant.
//  - inX_ready = slot free && grant==X. At most one ready is high per cycle.
//    No ready is asserted without the matching valid.
//  - On accept:
//    out_data <= rev ? bitreverse(data) : data, where bitreverse maps bit i -> bit 2**N-1-i.
//    out_src <= granted ID. last_grant <= granted ID.
//  - last_grant updates only on accept; an idle cycle does not change priority.
//  - Latency: input accept to out_valid is 1 cycle. Throughput is 1 word/cycle when out_ready=1.
//  - Fairness: under continuous contention grants strictly alternate 0,1,0,1.
//    No requester waits more than one transfer.
//  - out_ready=0 while FULL: out_data/out_src hold; both inX_ready=0.
//  - reset_n low mid-transfer: pending result discarded and out_valid drops immediately.
//    Producers must re-present after release.
//  - N=0 (1-bit) is legal; reversal is the identity.
// TESTING
//  1 reset: hold reset_n=0 -> out_valid=0, out_data=0, in0_ready=in1_ready=0.
//    Release with in0_valid=in1_valid=1 -> in0_ready=1 first.
//  2 single reverse: in0 0x01 rev=1, out_ready=1 -> next cycle out_valid=1, out_data=0x80, out_src=0.
//  3 pass-through: in1 0xB4 rev=0 -> out_data=0xB4, out_src=1.
//    Same word with rev=1 -> out_data=0x2D.
//  4 contention: both valid continuously for 6 cycles, out_ready=1 -> out_src sequence 0,1,0,1,0,1.
//    One word per cycle.
//  5 backpressure: out FULL, out_ready=0 for 3 cycles -> both readys 0, out_data held.
//    out_ready=1 -> next winner loaded same edge, no bubble.
//  6 async reset mid-stream: pulse reset_n low between edges -> out_valid=0 immediately.
//    Next grant goes to requester 0.

Source files
------------

// File: rtl/reverser_arbiter.sv
// Two-requester round-robin arbiter feeding a shared bit-reverser and a
// single-entry output register tagged with the winning requester ID.
module reverser_arbiter #(
  parameter int N = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in0_valid,
  input  logic [2**N-1:0] in0_data,
  input  logic            in0_rev,
  output logic            in0_ready,
  input  logic            in1_valid,
  input  logic [2**N-1:0] in1_data,
  input  logic            in1_rev,
  output logic            in1_ready,
  output logic            out_valid,
  output logic [2**N-1:0] out_data,
  output logic            out_src,
  input  logic            out_ready
);

  localparam int W = 2**N;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_t;

  stage_t         state;
  logic           last_grant;
  logic           slot_free;
  logic           gnt_valid;
  logic           gnt_id;
  logic           accept;
  logic           sel_rev;
  logic [W-1:0]   sel_data;
  logic [W-1:0]   rev_data;
  logic [W-1:0]   result;

  assign out_valid = (state == FULL);

  // A full slot is reusable in the same cycle the consumer drains it.
  assign slot_free = (state == EMPTY) || out_ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (in0_valid && in1_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = ~last_grant;
    end else if (in0_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b0;
    end else if (in1_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b1;
    end
  end

  assign accept    = slot_free && gnt_valid;
  assign in0_ready = accept && !gnt_id;
  assign in1_ready = accept &&  gnt_id;

  assign sel_data = gnt_id ? in1_data : in0_data;
  assign sel_rev  = gnt_id ? in1_rev  : in0_rev;

  always_comb begin
    rev_data = '0;
    for (int i = 0; i < W; i++) begin
      rev_data[i] = sel_data[W-1-i];
    end
  end

  assign result = sel_rev ? rev_data : sel_data;

  // last_grant resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset_n) begin
      state      <= EMPTY;
      out_data   <= '0;
      out_src    <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      state      <= FULL;
      out_data   <= result;
      out_src    <= gnt_id;
      last_grant <= gnt_id;
    end else if (out_ready) begin
      state      <= EMPTY;
    end
  end

endmodule

// File: tb/tb_reverser_arbiter.sv
// Self-checking bench for reverser_arbiter: directed scenarios plus a
// randomized run against a queue-free behavioural model of the arbiter.
module tb_reverser_arbiter;

  localparam int N = 3;
  localparam int W = 2**N;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in0_valid = 1'b0;
  logic [W-1:0] in0_data = '0;
  logic         in0_rev = 1'b0;
  logic         in0_ready;
  logic         in1_valid = 1'b0;
  logic [W-1:0] in1_data = '0;
  logic         in1_rev = 1'b0;
  logic         in1_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_src;
  logic         out_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  reverser_arbiter #(.N(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_rev   (in0_rev),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_rev   (in1_rev),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Bit reversal by shifting bits out of the LSB and into the result's LSB.
  function automatic logic [W-1:0] bitrev(input logic [W-1:0] x);
    logic [W-1:0] r;
    logic [W-1:0] t;
    r = '0;
    t = x;
    for (int k = 0; k < W; k++) begin
      r = {r[W-2:0], t[0]};
      t = t >> 1;
    end
    return r;
  endfunction

  task automatic drive(input logic v0, input logic [W-1:0] d0, input logic r0,
                       input logic v1, input logic [W-1:0] d1, input logic r1,
                       input logic ordy);
    @(negedge clk);
    in0_valid = v0; in0_data = d0; in0_rev = r0;
    in1_valid = v1; in1_data = d1; in1_rev = r1;
    out_ready = ordy;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=00", out_data); end
    checks++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got=%b%b exp=00", in0_ready, in1_ready);
    end
    drive(1'b1, 8'h5A, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1);
    reset_n = 1'b1;
    #1;
    checks++; if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
      errors++; $display("FAIL release_first_grant got=%b%b exp=10", in0_ready, in1_ready);
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_src !== 1'b0 || out_data !== 8'h5A) begin
      errors++; $display("FAIL release_out got=%b/%b/%h exp=1/0/5a", out_valid, out_src, out_data);
    end
  endtask

  task automatic test_single_reverse;
    drive(1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    #1;
    checks++; if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
      errors++; $display("FAIL rev_ready got=%b%b exp=10", in0_ready, in1_ready);
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h80 || out_src !== 1'b0) begin
      errors++; $display("FAIL single_reverse got=%b/%h/%b exp=1/80/0", out_valid, out_data, out_src);
    end
  endtask

  task automatic test_pass_through;
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'hB4, 1'b0, 1'b1);
    #1;
    checks++; if (in0_ready !== 1'b0 || in1_ready !== 1'b1) begin
      errors++; $display("FAIL pass_ready got=%b%b exp=01", in0_ready, in1_ready);
    end
    @(posedge clk); #1;
    checks++; if (out_data !== 8'hB4 || out_src !== 1'b1) begin
      errors++; $display("FAIL pass_through got=%h/%b exp=b4/1", out_data, out_src);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'hB4, 1'b1, 1'b1);
    @(posedge clk); #1;
    checks++; if (out_data !== 8'h2D || out_src !== 1'b1) begin
      errors++; $display("FAIL pass_reversed got=%h/%b exp=2d/1", out_data, out_src);
    end
  endtask

  task automatic test_contention;
    for (int k = 0; k < 6; k++) begin
      logic exp_src;
      exp_src = k[0];
      drive(1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1);
      #1;
      checks++; if (in0_ready !== !exp_src || in1_ready !== exp_src) begin
        errors++; $display("FAIL contention_ready[%0d] got=%b%b exp_src=%b", k, in0_ready, in1_ready, exp_src);
      end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_src !== exp_src || out_data !== (exp_src ? 8'h88 : 8'h11)) begin
        errors++; $display("FAIL contention_out[%0d] got=%b/%b/%h exp=1/%b/%h", k, out_valid, out_src,
                           out_data, exp_src, exp_src ? 8'h88 : 8'h11);
      end
    end
  endtask

  task automatic test_backpressure;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'h0F, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
      #1;
      checks++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
        errors++; $display("FAIL stall_ready[%0d] got=%b%b exp=00", k, in0_ready, in1_ready);
      end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h88 || out_src !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d] got=%b/%h/%b exp=1/88/1", k, out_valid, out_data, out_src);
      end
    end
    drive(1'b1, 8'h0F, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
    #1;
    checks++; if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
      errors++; $display("FAIL unstall_ready got=%b%b exp=10", in0_ready, in1_ready);
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hF0 || out_src !== 1'b0) begin
      errors++; $display("FAIL unstall_out got=%b/%h/%b exp=1/f0/0", out_valid, out_data, out_src);
    end
  endtask

  task automatic test_async_reset;
    drive(1'b1, 8'h0F, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_src !== 1'b0) begin
      errors++; $display("FAIL async_reset got=%b/%h/%b exp=0/00/0", out_valid, out_data, out_src);
    end
    #1 reset_n = 1'b1;
    #1;
    checks++; if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
      errors++; $display("FAIL post_reset_grant got=%b%b exp=10", in0_ready, in1_ready);
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_src !== 1'b0 || out_data !== 8'hF0) begin
      errors++; $display("FAIL post_reset_out got=%b/%b/%h exp=1/0/f0", out_valid, out_src, out_data);
    end
  endtask

  // Random producers that hold each word until it is taken, a random consumer,
  // and a model tracking the output slot and whoever was served last.
  task automatic test_random;
    logic         m_valid, m_src, m_last;
    logic [W-1:0] m_data;
    logic         p0v, p1v, p0r, p1r, a0, a1, ordy, free, e0, e1;
    logic [W-1:0] p0d, p1d;
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    m_valid = 1'b0; m_src = 1'b0; m_last = 1'b1; m_data = '0;
    p0v = 1'b0; p1v = 1'b0; p0r = 1'b0; p1r = 1'b0; p0d = '0; p1d = '0;
    a0 = 1'b0; a1 = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!p0v || a0) begin
        p0v = ($urandom_range(0, 3) != 0); p0d = W'($urandom); p0r = 1'($urandom);
      end
      if (!p1v || a1) begin
        p1v = ($urandom_range(0, 3) != 0); p1d = W'($urandom); p1r = 1'($urandom);
      end
      ordy = ($urandom_range(0, 3) != 0);
      drive(p0v, p0d, p0r, p1v, p1d, p1r, ordy);
      #1;
      free = !m_valid || ordy;
      e0 = free && p0v && (!p1v || m_last == 1'b1);
      e1 = free && p1v && (!p0v || m_last == 1'b0);
      checks++; if (in0_ready !== e0 || in1_ready !== e1) begin
        errors++; $display("FAIL rand_ready[%0d] got=%b%b exp=%b%b", cyc, in0_ready, in1_ready, e0, e1);
      end
      @(posedge clk); #1;
      a0 = e0; a1 = e1;
      if (e0) begin
        m_valid = 1'b1; m_data = p0r ? bitrev(p0d) : p0d; m_src = 1'b0; m_last = 1'b0;
      end else if (e1) begin
        m_valid = 1'b1; m_data = p1r ? bitrev(p1d) : p1d; m_src = 1'b1; m_last = 1'b1;
      end else if (ordy) begin
        m_valid = 1'b0;
      end
      checks++; if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_src !== m_src))) begin
        errors++; $display("FAIL rand_out[%0d] got=%b/%h/%b exp=%b/%h/%b", cyc, out_valid, out_data,
                           out_src, m_valid, m_data, m_src);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_reverse();
    test_pass_through();
    test_contention();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
